// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // SPI mode as the usual {CPOL, CPHA} pair.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, toggle index and edge strobes.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned  CLK_DIV = 4,
  parameter int unsigned  TOGGLES = 80,
  parameter bit           CPOL    = 1'b0,
  localparam int unsigned TW      = cnt_width(TOGGLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  output logic          o_sclk,
  output logic [TW-1:0] o_toggle_idx,
  output logic          o_lead_edge_c,
  output logic          o_trail_edge_c
);

  localparam int unsigned CW = cnt_width(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_toggle_c;

  // Strobes mark the clk edge that produces the next SCLK toggle.
  assign w_toggle_c     = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_lead_edge_c  = w_toggle_c && !o_toggle_idx[0];
  assign o_trail_edge_c = w_toggle_c &&  o_toggle_idx[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      o_toggle_idx <= '0;
      o_sclk       <= CPOL;
    end else if (!i_en) begin
      r_cnt        <= '0;
      o_toggle_idx <= '0;
      o_sclk       <= CPOL;
    end else if (w_toggle_c) begin
      r_cnt        <= '0;
      o_toggle_idx <= o_toggle_idx + TW'(1);
      o_sclk       <= ~o_sclk;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_rx_master.sv
// SPI master receiver: frames FRAME_BYTES bytes from MISO, MSB first, any CPOL/CPHA.
module spi_rx_master
  import spi_pkg::*;
#(
  parameter int unsigned  FRAME_BYTES = 5,
  parameter int unsigned  CLK_DIV     = 4,
  parameter bit           CPOL        = 1'b0,
  parameter bit           CPHA        = 1'b0,
  parameter int unsigned  SS_SETUP    = 2,
  parameter int unsigned  SS_HOLD     = 2,
  parameter bit           CONTINUOUS  = 1'b0,
  localparam int unsigned N           = 8 * FRAME_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         miso,
  output logic         sclk,
  output logic         ss,
  output logic         busy,
  output logic [N-1:0] dout,
  output logic         dout_valid
);

  localparam int unsigned TOGGLES = 2 * N;
  localparam int unsigned TW      = cnt_width(TOGGLES);
  localparam int unsigned DW      = cnt_width(umax(SS_SETUP, SS_HOLD));
  localparam int unsigned BW      = cnt_width(N);
  localparam spi_mode_t   MODE    = '{cpol: CPOL, cpha: CPHA};

  state_t        r_state;
  logic [DW-1:0] r_dly;
  logic [BW-1:0] r_bit;
  logic [N-1:0]  r_shift;

  logic          w_lead_c;
  logic          w_trail_c;
  logic          w_sample_c;
  logic          w_last_c;
  logic [TW-1:0] w_toggle_idx;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .TOGGLES (TOGGLES),
    .CPOL    (MODE.cpol)
  ) u_sclk_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (r_state == ST_XFER),
    .o_sclk         (sclk),
    .o_toggle_idx   (w_toggle_idx),
    .o_lead_edge_c  (w_lead_c),
    .o_trail_edge_c (w_trail_c)
  );

  assign w_sample_c = MODE.cpha ? w_trail_c : w_lead_c;
  assign w_last_c   = w_trail_c && (w_toggle_idx == TW'(TOGGLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dly      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      ss         <= 1'b1;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start || CONTINUOUS) begin
            r_state <= ST_SETUP;
            r_dly   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            ss      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (r_dly == DW'(SS_SETUP - 1)) begin
            r_dly   <= '0;
            r_state <= ST_XFER;
          end else begin
            r_dly <= r_dly + DW'(1);
          end
        end
        ST_XFER: begin
          // Bit counter guards against over-shifting past a full frame.
          if (w_sample_c && (r_bit != BW'(N))) begin
            r_shift <= {r_shift[N-2:0], miso};
            r_bit   <= r_bit + BW'(1);
          end
          if (w_last_c) begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_dly == DW'(SS_HOLD - 1)) begin
            r_dly      <= '0;
            r_state    <= ST_IDLE;
            ss         <= 1'b1;
            busy       <= 1'b0;
            dout       <= r_shift;
            dout_valid <= 1'b1;
          end else begin
            r_dly <= r_dly + DW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rx_master.sv
// Bench for spi_rx_master: seven configurations, SPI slave models and a cycle-level timing model.
module tb_spi_rx_master;

  localparam int NI = 7;

  function automatic int cfg_fb(input int g);
    return (g >= 1 && g <= 4) ? 2 : 5;
  endfunction
  function automatic int cfg_cd(input int g);
    return (g == 6) ? 2 : 4;
  endfunction
  function automatic bit cfg_cpol(input int g);
    return (g == 3 || g == 4);
  endfunction
  function automatic bit cfg_cpha(input int g);
    return (g == 2 || g == 4);
  endfunction
  function automatic int cfg_su(input int g);
    return (g == 6) ? 1 : 2;
  endfunction
  function automatic int cfg_ho(input int g);
    return (g == 6) ? 1 : 2;
  endfunction
  function automatic bit cfg_cont(input int g);
    return (g == 5);
  endfunction
  function automatic int cfg_n(input int g);
    return 8 * cfg_fb(g);
  endfunction
  // Cycles ss stays low: setup + 2N half-periods + hold.
  function automatic int cfg_len(input int g);
    return cfg_su(g) + 2 * cfg_n(g) * cfg_cd(g) + cfg_ho(g);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rstn_a  [NI];
  logic         start_a [NI];
  logic         ss_a    [NI];
  logic         sclk_a  [NI];
  logic         busy_a  [NI];
  logic         dv_a    [NI];
  logic [127:0] dout_a  [NI];
  logic [127:0] slv_data[NI];
  int           smp_a   [NI];

  int checks = 0;
  int errors = 0;

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int N = cfg_n(g);
      localparam bit P_CPOL = cfg_cpol(g);
      localparam bit P_CPHA = cfg_cpha(g);

      logic [N-1:0] dout_l;
      logic         miso = 1'b0;
      int           k = 0;
      int           smp = 0;
      logic         ss_prev = 1'b1;
      logic         sclk_prev = P_CPOL;
      logic [127:0] d;
      logic         lead;

      spi_rx_master #(
        .FRAME_BYTES (cfg_fb(g)),
        .CLK_DIV     (cfg_cd(g)),
        .CPOL        (P_CPOL),
        .CPHA        (P_CPHA),
        .SS_SETUP    (cfg_su(g)),
        .SS_HOLD     (cfg_ho(g)),
        .CONTINUOUS  (cfg_cont(g))
      ) u_dut (
        .clk        (clk),
        .rst_n      (rstn_a[g]),
        .start      (start_a[g]),
        .miso       (miso),
        .sclk       (sclk_a[g]),
        .ss         (ss_a[g]),
        .busy       (busy_a[g]),
        .dout       (dout_l),
        .dout_valid (dv_a[g])
      );

      assign dout_a[g] = 128'(dout_l);
      assign smp_a[g]  = smp;

      // SPI slave: CPHA=0 presents a bit at ss fall and shifts on trailing edges,
      // CPHA=1 shifts on leading edges; counts edges of the master's sampling kind.
      always @(ss_a[g] or sclk_a[g] or slv_data[g]) begin
        if (ss_prev && !ss_a[g]) begin
          k   = P_CPHA ? -1 : 0;
          smp = 0;
        end else if (!ss_a[g] && (sclk_a[g] != sclk_prev)) begin
          lead = (sclk_a[g] != P_CPOL);
          if (lead) begin
            if (P_CPHA) k++;
            else        smp++;
          end else begin
            if (!P_CPHA) k++;
            else         smp++;
          end
        end
        ss_prev   = ss_a[g];
        sclk_prev = sclk_a[g];
        d         = slv_data[g];
        miso      = (k >= 0 && k < N) ? d[N-1-k] : 1'b0;
      end
    end
  endgenerate

  // Timing model: m_d counts clk edges since the start was accepted.
  bit           m_act [NI];
  int           m_d   [NI];
  bit           m_dv  [NI];
  logic [127:0] m_dout[NI];

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!rstn_a[g]) begin
        m_act[g]  = 1'b0;
        m_d[g]    = 0;
        m_dv[g]   = 1'b0;
        m_dout[g] = '0;
      end else begin
        m_dv[g] = 1'b0;
        if (!m_act[g]) begin
          if (start_a[g] || cfg_cont(g)) begin
            m_act[g] = 1'b1;
            m_d[g]   = 0;
          end
        end else begin
          m_d[g]++;
          if (m_d[g] == cfg_len(g)) begin
            m_act[g]  = 1'b0;
            m_dv[g]   = 1'b1;
            m_dout[g] = slv_data[g] & ({128{1'b1}} >> (128 - cfg_n(g)));
          end
        end
      end
    end
  end

  function automatic int exp_sclk(input int g);
    int t;
    if (!m_act[g] || m_d[g] < cfg_su(g)) return int'(cfg_cpol(g));
    t = (m_d[g] - cfg_su(g)) / cfg_cd(g);
    if (t > 2 * cfg_n(g)) t = 2 * cfg_n(g);
    return int'(cfg_cpol(g)) ^ (t % 2);
  endfunction

  int dv_cnt  [NI];
  int dv_cyc  [NI];
  int run     [NI];
  int last_low[NI];
  int c5[3];
  int n5 = 0;

  initial begin
    for (int g = 0; g < NI; g++) begin
      dv_cnt[g] = 0; dv_cyc[g] = 0; run[g] = 0; last_low[g] = 0;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling clk edge.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!rstn_a[g]) begin
        chki($sformatf("rst_ss[%0d]", g), int'(ss_a[g]), 1);
        chki($sformatf("rst_busy[%0d]", g), int'(busy_a[g]), 0);
        chki($sformatf("rst_dv[%0d]", g), int'(dv_a[g]), 0);
        chki($sformatf("rst_sclk[%0d]", g), int'(sclk_a[g]), int'(cfg_cpol(g)));
        chkv($sformatf("rst_dout[%0d]", g), dout_a[g], '0);
      end else begin
        chki($sformatf("ss[%0d]", g), int'(ss_a[g]), int'(!m_act[g]));
        chki($sformatf("busy[%0d]", g), int'(busy_a[g]), int'(m_act[g]));
        chki($sformatf("dv[%0d]", g), int'(dv_a[g]), int'(m_dv[g]));
        chki($sformatf("sclk[%0d]", g), int'(sclk_a[g]), exp_sclk(g));
        chkv($sformatf("dout[%0d]", g), dout_a[g], m_dout[g]);
      end
      if (dv_a[g]) begin
        dv_cnt[g]++;
        dv_cyc[g] = cyc;
        chki($sformatf("sample_edges[%0d]", g), smp_a[g], cfg_n(g));
        if (g == 5 && n5 < 3) begin
          c5[n5] = cyc;
          n5++;
        end
      end
      if (!ss_a[g]) run[g]++;
      else begin
        if (dv_a[g]) last_low[g] = run[g];
        run[g] = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start(input int g);
    start_a[g] = 1'b1;
    step(1);
    start_a[g] = 1'b0;
  endtask

  task automatic wait_dv(input int g, input int target, input int budget);
    int n = 0;
    while (dv_cnt[g] < target && n < budget) begin
      step(1);
      n++;
    end
    chki($sformatf("dv_within_budget[%0d]", g), int'(dv_cnt[g] >= target), 1);
  endtask

  int t0;
  int t1;
  int dvc;

  initial begin
    for (int g = 0; g < NI; g++) begin
      rstn_a[g]   = 1'b1;
      start_a[g]  = 1'b0;
      slv_data[g] = '0;
    end
    slv_data[0] = 128'hA5_3C_F0_0F_81;
    for (int g = 1; g <= 4; g++) slv_data[g] = 128'hBEEF;
    slv_data[5] = 128'h01_02_03_04_05;
    slv_data[6] = 128'hC0_FF_EE_12_34;
    #1;
    for (int g = 0; g < NI; g++) rstn_a[g] = 1'b0;
    step(3);
    for (int g = 0; g < NI; g++) rstn_a[g] = 1'b1;
    step(2);
    chki("idle_ss", int'(ss_a[0]), 1);
    chkv("idle_dout", dout_a[0], 128'h0);

    // Defaults, the four modes and the fast configuration, all started together.
    t0 = cyc;
    for (int g = 0; g < NI; g++) if (g != 5) start_a[g] = 1'b1;
    step(1);
    for (int g = 0; g < NI; g++) start_a[g] = 1'b0;
    wait_dv(0, 1, 400);
    chki("latency_default", dv_cyc[0] - t0, 325);
    chki("ss_low_default", last_low[0], 324);
    chkv("dout_default", dout_a[0], 128'hA53CF00F81);
    for (int g = 1; g <= 4; g++) begin
      chki($sformatf("latency_mode%0d", g - 1), dv_cyc[g] - t0, 133);
      chki($sformatf("frames_mode%0d", g - 1), dv_cnt[g], 1);
      chkv($sformatf("dout_mode%0d", g - 1), dout_a[g], 128'hBEEF);
      chki($sformatf("sclk_idle_mode%0d", g - 1), int'(sclk_a[g]), int'(cfg_cpol(g)));
    end
    chki("latency_fast", dv_cyc[6] - t0, 163);
    chki("ss_low_fast", last_low[6], 162);
    chkv("dout_fast", dout_a[6], 128'hC0FFEE1234);

    // A second start during XFER must be ignored.
    dvc = dv_cnt[0];
    slv_data[0] = 128'h5A_5A_0F_0F_33;
    pulse_start(0);
    step(60);
    pulse_start(0);
    step(400);
    chki("start_in_xfer_frames", dv_cnt[0], dvc + 1);
    chkv("start_in_xfer_dout", dout_a[0], 128'h5A5A0F0F33);

    // Reset around bit 20 aborts the frame and clears dout.
    slv_data[0] = 128'hDE_AD_BE_EF_77;
    pulse_start(0);
    step(165);
    rstn_a[0] = 1'b0;
    #1;
    chki("abort_ss", int'(ss_a[0]), 1);
    chki("abort_busy", int'(busy_a[0]), 0);
    chkv("abort_dout", dout_a[0], 128'h0);
    step(2);
    rstn_a[0] = 1'b1;
    step(1);
    dvc = dv_cnt[0];
    slv_data[0] = 128'h11_22_33_44_55;
    pulse_start(0);
    wait_dv(0, dvc + 1, 400);
    chkv("after_abort_dout", dout_a[0], 128'h1122334455);

    // start held high gives back-to-back frames with a one-cycle gap.
    dvc = dv_cnt[0];
    slv_data[0] = 128'h01_23_45_67_89;
    start_a[0] = 1'b1;
    wait_dv(0, dvc + 1, 400);
    t1 = dv_cyc[0];
    step(100);
    start_a[0] = 1'b0;
    wait_dv(0, dvc + 2, 400);
    chki("held_start_period", dv_cyc[0] - t1, 325);
    step(400);
    chki("held_start_frames", dv_cnt[0], dvc + 2);
    chkv("held_start_dout", dout_a[0], 128'h0123456789);

    // Continuous instance has been free-running since reset release.
    chki("cont_frames_seen", int'(n5 >= 3), 1);
    chki("cont_period_1", c5[1] - c5[0], 325);
    chki("cont_period_2", c5[2] - c5[1], 325);
    chkv("cont_dout", dout_a[5], 128'h0102030405);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
